// File: rtl/rmon_pkg.sv
// Shared types and helpers for the RMON counter bank.
//   f_log2ceil   : ceil(log2(n)), used to size counter indices
//   rmon_state_t : bank sequencing state (INIT clears the RAM, RUN flushes/serves reads)
//   rmon_stage_t : S0->S1 pipeline register. Index and pending fields are sized for
//                  the largest supported bank and are truncated where they are used.
package rmon_pkg;

   localparam int unsigned c_idx_max_w  = 16;
   localparam int unsigned c_pend_max_w = 16;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } rmon_state_t;

   typedef struct packed {
      logic [c_idx_max_w-1:0]  index;
      logic [c_pend_max_w-1:0] pend;
      logic                    host;
      logic                    clr;
      logic                    valid;
   } rmon_stage_t;

   function automatic int f_log2ceil(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rmon_pend_cnt.sv
// Narrow pending event counter in flops.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   clr_i          : hold at zero (bank not running)
//   cap_i          : value is being folded into the RAM this cycle; reload with
//                    this cycle's event so nothing is lost
//   evt_i          : one count per high cycle
//   cnt_o          : current pending count
//   sat_o          : event arrived while full and not captured (event dropped)
module rmon_pend_cnt #(
   parameter int g_width = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               clr_i,
   input  logic               cap_i,
   input  logic               evt_i,
   output logic [g_width-1:0] cnt_o,
   output logic               sat_o
);

   logic [g_width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      sat_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cap_i) begin
         cnt_d = g_width'(evt_i);
      end else if (evt_i) begin
         if (&cnt_q) sat_o = 1'b1;
         else        cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rmon_cnt_bank.sv
// Multi-port RMON counter bank: per-event pending flop counters are folded by a
// round-robin flush engine into wide counters held in a simple-dual-port RAM.
// Host reads share the same two-stage pipeline and may clear on read.
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   events_i              : one event bit per counter
//   clr_all_i             : restart the RAM clear sequence
//   rd_req_i/rd_addr_i/rd_clr_i, rd_ready_o : host request handshake
//   rd_valid_o/rd_data_o  : read result, two cycles after acceptance
//   busy_o                : RAM clear in progress
//   ovf_o                 : sticky, a pending counter dropped an event
//
// state   | meaning
// ST_INIT | writing zero to every RAM word, one per cycle; events dropped
// ST_RUN  | flush engine and host reads active
module rmon_cnt_bank
   import rmon_pkg::*;
#(
   parameter  int g_nports     = 2,
   parameter  int g_cnt_pp     = 16,
   parameter  int g_pend_width = 4,
   parameter  int g_cnt_width  = 32,
   parameter  int g_wrap_mode  = 1,
   localparam int c_n          = g_nports * g_cnt_pp,
   localparam int c_aw         = f_log2ceil(c_n)
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [c_n-1:0]         events_i,
   input  logic                   clr_all_i,
   input  logic                   rd_req_i,
   input  logic [c_aw-1:0]        rd_addr_i,
   input  logic                   rd_clr_i,
   output logic                   rd_ready_o,
   output logic                   rd_valid_o,
   output logic [g_cnt_width-1:0] rd_data_o,
   output logic                   busy_o,
   output logic                   ovf_o
);

   localparam logic [c_aw-1:0] c_last = c_aw'(c_n - 1);

   rmon_state_t            state_q, state_d;
   logic [c_aw-1:0]        init_cnt_q, init_cnt_d;
   logic [c_aw-1:0]        rr_q, rr_d;
   rmon_stage_t            s1_q, s1_d;
   logic                   ovf_q, ovf_d;
   logic                   rd_valid_q;
   logic [g_cnt_width-1:0] rd_data_q;
   logic                   fwd_q;
   logic [g_cnt_width-1:0] fwd_data_q;

   logic [g_cnt_width-1:0]  mem [c_n];
   logic [g_cnt_width-1:0]  mem_rd_q;
   logic [g_pend_width-1:0] pend [c_n];
   logic [c_n-1:0]          sat, cap;

   logic                    run, host_acc, s1_fire;
   logic [c_aw-1:0]         s0_idx, s1_idx;
   logic [g_cnt_width-1:0]  base, sum;
   logic [g_cnt_width:0]    sum_ext;
   logic                    wr_en;
   logic [c_aw-1:0]         wr_addr;
   logic [g_cnt_width-1:0]  wr_data;
   logic                    unused_stage;

   assign run      = (state_q == ST_RUN);
   assign host_acc = run && rd_req_i;
   assign s0_idx   = host_acc ? rd_addr_i : rr_q;

   always_comb begin
      cap = '0;
      if (run) cap[s0_idx] = 1'b1;
   end

   for (genvar k = 0; k < c_n; k++) begin : g_pend
      rmon_pend_cnt #(.g_width(g_pend_width)) u_pend (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .clr_i   (!run),
         .cap_i   (cap[k]),
         .evt_i   (events_i[k]),
         .cnt_o   (pend[k]),
         .sat_o   (sat[k])
      );
   end

   always_comb begin
      s1_d       = '0;
      s1_d.index = c_idx_max_w'(s0_idx);
      s1_d.pend  = c_pend_max_w'(pend[s0_idx]);
      s1_d.host  = host_acc;
      s1_d.clr   = host_acc && rd_clr_i;
      s1_d.valid = run && !clr_all_i;
   end

   // Upper stage bits beyond this instance's widths are intentionally dropped.
   assign unused_stage = ^s1_q;

   // An op already in S1 when clr_all_i arrives is squashed as well.
   assign s1_fire = s1_q.valid && !clr_all_i;
   assign s1_idx  = s1_q.index[c_aw-1:0];
   assign base    = fwd_q ? fwd_data_q : mem_rd_q;
   assign sum_ext = {1'b0, base} + (g_cnt_width+1)'(s1_q.pend[g_pend_width-1:0]);
   assign sum     = (g_wrap_mode == 0 && sum_ext[g_cnt_width]) ? '1
                                                               : sum_ext[g_cnt_width-1:0];

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = s1_idx;
      wr_data = '0;
      if (!run) begin
         wr_en   = 1'b1;
         wr_addr = c_last - init_cnt_q;
      end else if (s1_fire) begin
         wr_en   = 1'b1;
         wr_data = s1_q.clr ? '0 : sum;
      end
   end

   // Read-before-write RAM; a same-address write is picked up by the S1 bypass.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      mem_rd_q <= mem[s0_idx];
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (clr_all_i) begin
         state_d    = ST_INIT;
         init_cnt_d = c_last;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (init_cnt_q == '0) state_d = ST_RUN;
               else                  init_cnt_d = init_cnt_q - 1'b1;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
         endcase
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (!run)          rr_d = '0;
      else if (!host_acc) rr_d = (rr_q == c_last) ? '0 : rr_q + 1'b1;
   end

   assign ovf_d = (run && !clr_all_i) ? (ovf_q | (|sat)) : 1'b0;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_INIT;
         init_cnt_q <= c_last;
         rr_q       <= '0;
         s1_q       <= '0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         rr_q       <= rr_d;
         s1_q       <= s1_d;
         ovf_q      <= ovf_d;
         rd_valid_q <= s1_fire && s1_q.host;
         if (s1_fire && s1_q.host) rd_data_q <= sum;
         fwd_q      <= wr_en && (wr_addr == s0_idx);
         fwd_data_q <= wr_data;
      end
   end

   assign rd_ready_o = run;
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;
   assign busy_o     = !run;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_rmon_cnt_bank.sv
// Directed bench for rmon_cnt_bank. Three banks share stimulus: the default
// 32-bit wrap bank plus 8-bit wrap and 8-bit saturate variants, whose expected
// values are derived from the 32-bit expectation.
module tb_rmon_cnt_bank;

   localparam int c_n = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [c_n-1:0] events;
   logic           clr_all, rd_req, rd_clr;
   logic [4:0]     rd_addr;

   logic        rdy_m, val_m, busy_m, ovf_m;
   logic [31:0] dat_m;
   logic        rdy_w, val_w, busy_w, ovf_w;
   logic [7:0]  dat_w;
   logic        rdy_s, val_s, busy_s, ovf_s;
   logic [7:0]  dat_s;

   int n_vec = 0;
   int n_err = 0;
   int hi7   = 0;

   always #5 clk = ~clk;

   rmon_cnt_bank u_main (
      .clk_i(clk), .rst_n_i(rst_n), .events_i(events), .clr_all_i(clr_all),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_clr_i(rd_clr),
      .rd_ready_o(rdy_m), .rd_valid_o(val_m), .rd_data_o(dat_m),
      .busy_o(busy_m), .ovf_o(ovf_m)
   );

   rmon_cnt_bank #(.g_cnt_width(8), .g_wrap_mode(1)) u_wrap8 (
      .clk_i(clk), .rst_n_i(rst_n), .events_i(events), .clr_all_i(clr_all),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_clr_i(rd_clr),
      .rd_ready_o(rdy_w), .rd_valid_o(val_w), .rd_data_o(dat_w),
      .busy_o(busy_w), .ovf_o(ovf_w)
   );

   rmon_cnt_bank #(.g_cnt_width(8), .g_wrap_mode(0)) u_sat8 (
      .clk_i(clk), .rst_n_i(rst_n), .events_i(events), .clr_all_i(clr_all),
      .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_clr_i(rd_clr),
      .rd_ready_o(rdy_s), .rd_valid_o(val_s), .rd_data_o(dat_s),
      .busy_o(busy_s), .ovf_o(ovf_s)
   );

   typedef enum int {V_READ, V_PULSE, V_WAIT} vop_t;
   typedef struct {
      vop_t op;
      int   addr;
      bit   clr;
      int   n;
      int   exp;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      if (events[7]) hi7++;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int a, input int n);
      for (int i = 0; i < n; i++) begin
         events[a] = 1'b1;
         step();
         events[a] = 1'b0;
         step();
         step();
      end
   endtask

   task automatic do_read(input int addr, input bit clr, input int exp, input string name);
      int ew, es;
      ew = exp % 256;
      es = (exp > 255) ? 255 : exp;
      rd_addr = 5'(addr);
      rd_clr  = clr;
      rd_req  = 1'b1;
      chk({name, " ready"}, 32'(rdy_m), 32'd1);
      step();
      rd_req = 1'b0;
      rd_clr = 1'b0;
      chk({name, " valid t+1"}, 32'(val_m), 32'd0);
      step();
      chk({name, " valid t+2"}, 32'(val_m), 32'd1);
      chk({name, " data"}, dat_m, 32'(exp));
      chk({name, " data w8"}, 32'(dat_w), 32'(ew));
      chk({name, " data s8"}, 32'(dat_s), 32'(es));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int nb, e1, e2, er1, r1, r2;
      bit seen;

      vt[0]  = '{V_READ,  0,  1'b0, 0,   0};
      vt[1]  = '{V_READ,  17, 1'b0, 0,   0};
      vt[2]  = '{V_READ,  31, 1'b0, 0,   0};
      vt[3]  = '{V_PULSE, 5,  1'b0, 10,  0};
      vt[4]  = '{V_WAIT,  0,  1'b0, 40,  0};
      vt[5]  = '{V_READ,  5,  1'b0, 0,   10};
      vt[6]  = '{V_READ,  5,  1'b1, 0,   10};
      vt[7]  = '{V_READ,  5,  1'b0, 0,   0};
      vt[8]  = '{V_PULSE, 2,  1'b0, 300, 0};
      vt[9]  = '{V_WAIT,  0,  1'b0, 40,  0};
      vt[10] = '{V_READ,  2,  1'b0, 0,   300};
      vt[11] = '{V_PULSE, 31, 1'b0, 3,   0};
      vt[12] = '{V_READ,  31, 1'b1, 0,   3};
      vt[13] = '{V_READ,  31, 1'b0, 0,   0};
      vt[14] = '{V_PULSE, 9,  1'b0, 7,   0};
      vt[15] = '{V_READ,  9,  1'b1, 0,   7};

      rst_n   = 1'b0;
      events  = '0;
      clr_all = 1'b0;
      rd_req  = 1'b0;
      rd_clr  = 1'b0;
      rd_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy_m), 32'd1);
      chk("reset ready", 32'(rdy_m), 32'd0);
      chk("reset valid", 32'(val_m), 32'd0);
      chk("reset data", dat_m, 32'd0);
      chk("reset ovf", 32'(ovf_m), 32'd0);

      rst_n = 1'b1;
      chk("init ready", 32'(rdy_m), 32'd0);
      nb = 0;
      while (busy_m && nb < 100) begin
         nb++;
         step();
      end
      chk("init busy cycles", 32'(nb), 32'd32);

      for (int i = 0; i < 16; i++) begin
         case (vt[i].op)
            V_READ:  do_read(vt[i].addr, vt[i].clr, vt[i].exp, $sformatf("vec%0d read", i));
            V_PULSE: pulse(vt[i].addr, vt[i].n);
            default: repeat (vt[i].n) step();
         endcase
      end

      // Back-to-back reads of a continuously counting index.
      hi7 = 0;
      events[7] = 1'b1;
      repeat (5) step();
      e1 = hi7;
      rd_addr = 5'd7;
      rd_clr  = 1'b0;
      rd_req  = 1'b1;
      step();
      e2 = hi7;
      step();
      rd_req = 1'b0;
      chk("fwd valid 1", 32'(val_m), 32'd1);
      chk("fwd data 1", dat_m, 32'(e1));
      step();
      chk("fwd valid 2", 32'(val_m), 32'd1);
      chk("fwd data 2", dat_m, 32'(e2));

      er1 = hi7;
      rd_clr = 1'b1;
      rd_req = 1'b1;
      step();
      step();
      rd_req = 1'b0;
      rd_clr = 1'b0;
      chk("cor valid 1", 32'(val_m), 32'd1);
      r1 = int'(dat_m);
      chk("cor data 1", dat_m, 32'(er1));
      step();
      chk("cor valid 2", 32'(val_m), 32'd1);
      r2 = int'(dat_m);
      chk("cor data 2", dat_m, 32'd1);
      repeat (4) step();
      events[7] = 1'b0;
      repeat (3) step();
      do_read(7, 1'b1, hi7 - er1 - 1, "cor read 3");
      chk("cor sum", 32'(r1 + r2 + int'(dat_m)), 32'(hi7));
      do_read(7, 1'b1, 0, "cor read 4");

      // Host reads starve the flush engine while index 0 overflows.
      rd_addr = 5'd1;
      rd_req  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         events[0] = (i % 2 == 0);
         step();
      end
      events[0] = 1'b0;
      rd_req    = 1'b0;
      chk("starve ovf", 32'(ovf_m), 32'd1);
      chk("starve idx1 data", dat_m, 32'd0);
      repeat (40) step();
      chk("starve ovf sticky", 32'(ovf_m), 32'd1);
      do_read(0, 1'b0, 15, "starve idx0");

      // clr_all the cycle after a read is accepted.
      pulse(3, 4);
      repeat (40) step();
      pulse(4, 2);
      rd_addr = 5'd3;
      rd_req  = 1'b1;
      step();
      rd_req  = 1'b0;
      clr_all = 1'b1;
      step();
      clr_all = 1'b0;
      chk("clr squash valid", 32'(val_m), 32'd0);
      chk("clr ovf", 32'(ovf_m), 32'd0);
      chk("clr ready", 32'(rdy_m), 32'd0);
      nb   = 0;
      seen = 1'b0;
      while (busy_m && nb < 100) begin
         nb++;
         if (val_m) seen = 1'b1;
         step();
      end
      chk("clr busy cycles", 32'(nb), 32'd32);
      chk("clr no valid", 32'(seen), 32'd0);
      for (int k = 0; k < c_n; k++) do_read(k, 1'b0, 0, $sformatf("clr idx%0d", k));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rmon_cnt_bank.md
Name: rmon_cnt_bank

Overview:
Parametrised RMON counter bank, the multi-port successor of the single-port event counter. Each of g_nports*g_cnt_pp event inputs feeds a narrow pending counter held in flops. A round-robin flush engine folds the pending counts into wide counters kept in an inferred simple-dual-port RAM. A host read port returns a counter value, with optional clear-on-read, coherently with in-flight flushes.

Parameters:
g_nports, 2, number of ports.
g_cnt_pp, 16, event counters per port. N = g_nports*g_cnt_pp, and N must be >= 2.
g_pend_width, 4, width of each pending (flop) counter.
g_cnt_width, 32, width of each RAM counter.
g_wrap_mode, 1, 1 = RAM counters wrap modulo 2^g_cnt_width; 0 = they saturate at all-ones.

Ports:
clk_i  in  1  system clock.
rst_n_i  in  1  reset, synchronous, active-low.
events_i  in  N  event pulses; bit k = port k/g_cnt_pp, counter k%g_cnt_pp; one count per high cycle.
clr_all_i  in  1  pulse; restarts the INIT sequence.
rd_req_i  in  1  host read request.
rd_addr_i  in  clog2(N)  counter index.
rd_clr_i  in  1  clear-on-read qualifier, sampled with rd_req_i.
rd_ready_o  out  1  request accepted when rd_req_i && rd_ready_o.
rd_valid_o  out  1  one-cycle strobe: rd_data_o valid.
rd_data_o  out  g_cnt_width  counter value.
busy_o  out  1  INIT in progress.
ovf_o  out  1  sticky: a pending counter saturated.

Behaviour:
- Reset state: all outputs 0 except busy_o=1. All pending counters = 0. FSM enters INIT.
- FSM states INIT and RUN.
  - INIT: writes 0 to RAM addresses 0..N-1, one per cycle. busy_o=1, rd_ready_o=0. Pending counters are held at 0 and events are dropped. Exactly N cycles in INIT, then RUN.
  - clr_all_i in RUN: go to INIT. ovf_o clears. In-flight stage-1 ops are squashed: no RAM write, no rd_valid_o.
  - Reset mid-operation: same as clr_all_i, and all outputs return to reset values.
- Pending counter k:
  - increments on events_i[k].
  - If not captured and already at 2^g_pend_width-1 with an event: holds the value and sets ovf_o.
  - When captured: next value = events_i[k] ? 1 : 0, so no event is lost.
- rd_ready_o = 1 in RUN, so back-to-back requests are allowed.
- Pipeline, one op per cycle:
  - S0: index = rd_addr_i if a request is accepted, else the RR pointer. The RR pointer does not advance on host cycles and wraps N-1 to 0. Capture pend[index] into p. Register the RAM read address.
  - S1: base = RAM data, or the last write value if index equals the previous cycle's write index (forwarding). sum = base + zero-extended p.
    - Wrap mode: sum mod 2^g_cnt_width. Saturate mode: clamp to all-ones.
    - At the end of S1: RAM[index] <= (host && clr) ? 0 : sum.
    - Host op: rd_data_o <= sum and rd_valid_o <= 1.
- Latency: acceptance in cycle t gives rd_valid_o high in cycle t+2. rd_data_o holds its value until the next host op.
- The returned value includes every event up to and including cycle t-1. An event in cycle t lands in the pending counter.
- RAM: read-before-write on same-address collision. Coherence is guaranteed solely by the S1 forwarding path.

Decomposition:
- Package rmon_pkg: f_log2ceil function, FSM state enum {INIT, RUN}, stage-register struct (index, pending value, host flag, clr flag, valid).
- Sub-module rmon_pend_cnt: one saturating pending counter with capture/reload and a saturation flag, instantiated N times in a generate loop.
- RAM, flush pipeline and FSM live in rmon_cnt_bank.

Test Plan:
- Reset release, N=32 -> busy_o high exactly 32 cycles. Reads of indices 0, 17 and 31 return 0. rd_valid_o 2 cycles after acceptance.
- 10 single pulses on events_i[5], wait 40 cycles, read 5 -> 10. Read 5 again with rd_clr_i -> 10. Read 5 again -> 0.
- events_i[7] held high; accept reads of index 7 in consecutive cycles t and t+1 -> second value equals first +1 (forwarding). Sum of all clear-on-read results equals total pulses.
- g_cnt_width=8, 300 pulses on index 2: g_wrap_mode=1 -> 44; g_wrap_mode=0 -> 255.
- g_pend_width=4; host reads index 1 every cycle, starving RR, while index 0 gets 20 pulses -> ovf_o=1. After reads stop, index 0 reads 15.
- clr_all_i asserted one cycle after a read is accepted -> no rd_valid_o for that read, busy_o high N cycles, ovf_o=0, all counters read 0.
